// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - sums VEC_LEN multiplier products into one dot-product term
//
// Purpose:
//   Sits directly downstream of an unsigned DATA_WIDTH x DATA_WIDTH multiplier.
//   It accumulates VEC_LEN consecutive products into one matrix-multiply term.
//   The finished sum is held on outData until the consumer takes it.
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous, active-high reset
//   inClear    in   1             synchronous abort of partial sum / held result
//   inProduct  in   2*DATA_WIDTH  product from the multiplier
//   inValid    in   1             inProduct valid
//   inReady    out  1             product can be accepted this cycle
//   outData    out  ACC_WIDTH     completed dot product (registered)
//   outValid   out  1             outData valid
//   outReady   in   1             consumer accepts outData

module dot_product_accumulator #(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_LEN    = 4,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(VEC_LEN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inClear,
   input  logic [2*DATA_WIDTH-1:0] inProduct,
   input  logic                    inValid,
   output logic                    inReady,
   output logic [ACC_WIDTH-1:0]    outData,
   output logic                    outValid,
   input  logic                    outReady
);

   localparam int CNT_WIDTH = $clog2(VEC_LEN);
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VEC_LEN - 1);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t                r_state;
   logic [ACC_WIDTH-1:0]  r_acc;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_in_ready;
   logic                  r_out_valid;

   logic                  w_accept;
   logic [ACC_WIDTH-1:0]  w_product_ext;

   // r_in_ready is only ever high in ACCUM, so it doubles as the state qualifier.
   assign w_accept      = inValid & r_in_ready;
   assign w_product_ext = ACC_WIDTH'(inProduct);

   // The accumulator itself drives outData: in DONE it holds the final sum.
   assign outData  = r_acc;
   assign inReady  = r_in_ready;
   assign outValid = r_out_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ACCUM;
         r_acc       <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (inClear) begin
         // Clear wins over everything: a product presented now is dropped.
         // A result being handed off this cycle has already been taken
         // by the consumer at this edge.
         r_state     <= ACCUM;
         r_acc       <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (r_state == ACCUM) begin
         if (w_accept) begin
            r_acc <= r_acc + w_product_ext;
            if (r_count == LAST_IDX) begin
               r_count     <= '0;
               r_state     <= DONE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b1;
            end else begin
               r_count <= r_count + 1'b1;
            end
         end
      end else begin
         // DONE: hold the result until the consumer takes it.
         if (outReady) begin
            r_acc       <= '0;
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - self-checking bench for dot_product_accumulator

module tb_dot_product_accumulator;

   localparam int DW = 8;
   localparam int VL = 4;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          inClear;
   logic [15:0]   inProduct;
   logic          inValid;
   logic          inReady;
   logic [AW-1:0] outData;
   logic          outValid;
   logic          outReady;

   always #5 clk = ~clk;

   dot_product_accumulator #(
      .DATA_WIDTH(DW),
      .VEC_LEN   (VL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .inClear  (inClear),
      .inProduct(inProduct),
      .inValid  (inValid),
      .inReady  (inReady),
      .outData  (outData),
      .outValid (outValid),
      .outReady (outReady)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: products of the current vector, plus the held result.
   int m_q[$];
   bit m_hold;
   int m_res;

   int exp_q[$];
   int got_q[$];
   int pulses;
   bit prev_valid;

   typedef struct {
      int p[VL];
      int expected;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic cycle(bit clr, bit vld, int prod, bit ordy);
      inClear   = clr;
      inValid   = vld;
      inProduct = 16'(prod);
      outReady  = ordy;
      if (outValid && ordy) got_q.push_back(int'(outData));
      @(posedge clk);
      if (m_hold && ordy) begin
         exp_q.push_back(m_res);
         m_hold = 1'b0;
      end else if (!m_hold && vld && !clr) begin
         m_q.push_back(prod);
         if (m_q.size() == VL) begin
            m_res = 0;
            foreach (m_q[k]) m_res += m_q[k];
            m_q.delete();
            m_hold = 1'b1;
         end
      end
      if (clr) begin
         m_q.delete();
         m_hold = 1'b0;
      end
      #1;
      chk("in_ready", int'(inReady), int'(!m_hold));
      chk("out_valid", int'(outValid), int'(m_hold));
      if (m_hold) chk("out_data", int'(outData), m_res);
      if (outValid && !prev_valid) pulses++;
      prev_valid = outValid;
   endtask

   task automatic expect_results(string name, int req[$]);
      chk({name, "_count"}, got_q.size(), req.size());
      chk({name, "_model_count"}, exp_q.size(), req.size());
      for (int i = 0; i < req.size() && i < got_q.size(); i++)
         chk({name, "_value"}, got_q[i], req[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   // Called at posedge+1: asserts rst mid-cycle and checks outputs before any edge.
   task automatic reset_now(string name);
      #3;
      rst = 1'b1;
      #1;
      chk({name, "_valid"}, int'(outValid), 0);
      chk({name, "_data"}, int'(outData), 0);
      chk({name, "_ready"}, int'(inReady), 1);
      inValid = 1'b0;
      inClear = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_q.delete();
      m_hold = 1'b0;
      prev_valid = 1'b0;
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      tbl[0] = '{p: '{1, 1, 1, 1},                 expected: 4};
      tbl[1] = '{p: '{65025, 65025, 65025, 65025}, expected: 260100};
      tbl[2] = '{p: '{5, 6, 7, 8},                 expected: 26};
      tbl[3] = '{p: '{0, 0, 0, 0},                 expected: 0};
      tbl[4] = '{p: '{100, 200, 300, 400},         expected: 1000};

      rst = 1'b1; inClear = 1'b0; inValid = 1'b0; inProduct = '0; outReady = 1'b0;
      m_hold = 1'b0; pulses = 0; prev_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", int'(inReady), 1);
      chk("reset_valid", int'(outValid), 0);
      chk("reset_data", int'(outData), 0);
      rst = 1'b0;

      // Async reset with a partial sum of 300 after two products.
      cycle(0, 1, 100, 1);
      cycle(0, 1, 200, 1);
      reset_now("rst_partial");
      for (int i = 0; i < VL; i++) cycle(0, 1, 1, 1);
      chk("rst_then_sum", int'(outData), 4);
      cycle(0, 0, 0, 1);
      expect_results("rst_then", '{4});

      // Async reset while a result is held: it must never be delivered.
      for (int i = 0; i < VL; i++) cycle(0, 1, 3, 0);
      cycle(0, 0, 0, 0);
      reset_now("rst_done");
      cycle(0, 0, 0, 1);
      expect_results("rst_done_none", '{});

      // Table vectors, back-to-back at peak rate.
      foreach (tbl[i]) begin
         for (int j = 0; j < VL; j++) cycle(0, 1, tbl[i].p[j], 1);
         chk("tbl_valid", int'(outValid), 1);
         chk("tbl_data", int'(outData), tbl[i].expected);
         cycle(0, 1, 7, 1);
         chk("tbl_back_to_accum", int'(inReady), 1);
      end
      expect_results("tbl", '{4, 260100, 26, 0, 1000});

      // Bubbles: 1,2,3,4 with 0,3,1 idle cycles between.
      pulses = 0;
      cycle(0, 1, 1, 1);
      cycle(0, 1, 2, 1);
      repeat (3) cycle(0, 0, 0, 1);
      cycle(0, 1, 3, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 1, 4, 1);
      repeat (2) cycle(0, 0, 0, 1);
      chk("bubble_pulses", pulses, 1);
      expect_results("bubble", '{10});

      // Backpressure: 99 offered while the result is held must be ignored.
      cycle(0, 1, 5, 1); cycle(0, 1, 6, 1); cycle(0, 1, 7, 1); cycle(0, 1, 8, 1);
      repeat (5) cycle(0, 1, 99, 0);
      chk("bp_held", int'(outData), 26);
      cycle(0, 1, 99, 1);
      for (int i = 0; i < VL; i++) cycle(0, 1, 1, 1);
      cycle(0, 0, 0, 1);
      expect_results("backpressure", '{26, 4});

      // Abort after two products.
      cycle(0, 1, 100, 1); cycle(0, 1, 200, 1);
      cycle(1, 0, 0, 1);
      cycle(0, 1, 5, 1); cycle(0, 1, 6, 1); cycle(0, 1, 7, 1); cycle(0, 1, 8, 1);
      cycle(0, 0, 0, 1);
      expect_results("abort", '{26});

      // Clear together with the last product of a vector.
      pulses = 0;
      cycle(0, 1, 2, 1); cycle(0, 1, 2, 1); cycle(0, 1, 2, 1);
      cycle(1, 1, 2, 1);
      repeat (2) cycle(0, 0, 0, 1);
      chk("race_no_pulse", pulses, 0);
      for (int i = 0; i < VL; i++) cycle(0, 1, 2, 1);
      chk("race_next_valid", int'(outValid), 1);
      cycle(0, 0, 0, 1);
      chk("race_pulses", pulses, 1);
      expect_results("race", '{8});

      // Clear together with an output handshake: the handshake still completes.
      for (int i = 0; i < VL; i++) cycle(0, 1, 9, 0);
      cycle(1, 0, 0, 1);
      cycle(0, 0, 0, 1);
      expect_results("clear_handshake", '{36});

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         cycle($urandom_range(0, 29) == 0,
               $urandom_range(0, 9) < 7,
               int'($urandom_range(0, 65535)),
               $urandom_range(0, 9) < 6);
      end
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      chk("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk("rand_value", got_q[i], exp_q[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
